// File: rtl/rect_overlay_pkg.sv
// Shared encodings for the rectangle overlay controller: register fields,
// descriptor bit positions and FSM states.
package rect_overlay_pkg;
   localparam int H_ACTIVE = 800;
   localparam int V_ACTIVE = 600;

   localparam logic [1:0] F_X0 = 2'd0;
   localparam logic [1:0] F_X1 = 2'd1;
   localparam logic [1:0] F_Y0 = 2'd2;
   localparam logic [1:0] F_Y1 = 2'd3;

   localparam int EN_BIT = 15;
   localparam int RGB_HI = 14;
   localparam int RGB_LO = 12;

   typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;

   // Background colour register sits just past the last rectangle slot
   function automatic int bg_addr(int num_rect);
      return num_rect * 4;
   endfunction
endpackage

// File: rtl/rect_overlay_ctrl_if.sv
// Host configuration/commit port of the rectangle overlay controller.
interface rect_overlay_ctrl_if #(
   parameter int NUM_RECT = 4
);
   localparam int AW = $clog2(NUM_RECT) + 3;

   logic          cfg_valid;
   logic          cfg_ready;
   logic [AW-1:0] cfg_addr;
   logic [15:0]   cfg_wdata;
   logic          commit_req;
   logic          commit_pending;
   logic          commit_done;

   modport master (
      output cfg_valid, cfg_addr, cfg_wdata, commit_req,
      input  cfg_ready, commit_pending, commit_done
   );

   modport slave (
      input  cfg_valid, cfg_addr, cfg_wdata, commit_req,
      output cfg_ready, commit_pending, commit_done
   );
endinterface

// File: rtl/rect_overlay_ctrl_rect_hit.sv
// Inclusive point-in-rectangle test; inverted bounds never hit.
module rect_hit #(
   parameter int COORD_W = 10
) (
   input  logic               en,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] y1,
   input  logic [COORD_W-1:0] xpos,
   input  logic [COORD_W-1:0] ypos,
   output logic               hit
);
   assign hit = en && (xpos >= x0) && (xpos <= x1) && (ypos >= y0) && (ypos <= y1);
endmodule

// File: rtl/rect_overlay_ctrl.sv
// Double-buffered rectangle overlay: host writes a shadow bank, the active
// bank is refreshed one slot per cycle right after frame_start.
module rect_overlay_ctrl
   import rect_overlay_pkg::*;
#(
   parameter int NUM_RECT = 4,
   parameter int COORD_W  = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   rect_overlay_ctrl_if.slave cfg,
   input  logic               frame_start,
   input  logic               valid,
   input  logic [COORD_W-1:0] xpos,
   input  logic [COORD_W-1:0] ypos,
   output logic               vga_r,
   output logic               vga_g,
   output logic               vga_b
);
   localparam int IW = $clog2(NUM_RECT);
   localparam int AW = IW + 3;

   logic [NUM_RECT-1:0]              sh_en, act_en;
   logic [NUM_RECT-1:0][2:0]         sh_rgb, act_rgb;
   logic [NUM_RECT-1:0][COORD_W-1:0] sh_x0, sh_x1, sh_y0, sh_y1;
   logic [NUM_RECT-1:0][COORD_W-1:0] act_x0, act_x1, act_y0, act_y1;
   logic [2:0]                       sh_bg, act_bg;

   state_t              state, state_nxt;
   logic [IW-1:0]       cnt;
   logic                last, wr, w_rect;
   logic [IW-1:0]       w_idx;
   logic [NUM_RECT-1:0] hit;
   logic [2:0]          pix;
   logic                unused_wdata;

   assign last         = (state == COPY) && (cnt == IW'(NUM_RECT - 1));
   assign wr           = cfg.cfg_valid && (state != COPY);
   assign w_rect       = ~cfg.cfg_addr[AW-1];
   assign w_idx        = cfg.cfg_addr[AW-2:2];
   assign unused_wdata = ^cfg.cfg_wdata[11:10];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= (state == COPY) ? cnt + IW'(1) : '0;
      end
   end

   // Done fires in the last copy cycle so it lands NUM_RECT cycles after frame_start
   always_comb begin
      state_nxt          = state;
      cfg.cfg_ready      = 1'b1;
      cfg.commit_pending = 1'b0;
      cfg.commit_done    = 1'b0;
      case (state)
         IDLE:    if (cfg.commit_req) state_nxt = PENDING;
         PENDING: begin
            cfg.commit_pending = 1'b1;
            if (frame_start) state_nxt = COPY;
         end
         COPY: begin
            cfg.cfg_ready      = 1'b0;
            cfg.commit_pending = !last;
            cfg.commit_done    = last;
            if (last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_en  <= '0;
         sh_rgb <= '0;
         sh_x0  <= '0;
         sh_x1  <= '0;
         sh_y0  <= '0;
         sh_y1  <= '0;
         sh_bg  <= '0;
      end else if (wr) begin
         if (w_rect) begin
            case (cfg.cfg_addr[1:0])
               F_X0: begin
                  sh_en[w_idx]  <= cfg.cfg_wdata[EN_BIT];
                  sh_rgb[w_idx] <= cfg.cfg_wdata[RGB_HI:RGB_LO];
                  sh_x0[w_idx]  <= cfg.cfg_wdata[COORD_W-1:0];
               end
               F_X1:    sh_x1[w_idx] <= cfg.cfg_wdata[COORD_W-1:0];
               F_Y0:    sh_y0[w_idx] <= cfg.cfg_wdata[COORD_W-1:0];
               default: sh_y1[w_idx] <= cfg.cfg_wdata[COORD_W-1:0];
            endcase
         end else if (cfg.cfg_addr == AW'(bg_addr(NUM_RECT))) begin
            sh_bg <= cfg.cfg_wdata[2:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_en  <= '0;
         act_rgb <= '0;
         act_x0  <= '0;
         act_x1  <= '0;
         act_y0  <= '0;
         act_y1  <= '0;
         act_bg  <= '0;
      end else if (state == COPY) begin
         act_en[cnt]  <= sh_en[cnt];
         act_rgb[cnt] <= sh_rgb[cnt];
         act_x0[cnt]  <= sh_x0[cnt];
         act_x1[cnt]  <= sh_x1[cnt];
         act_y0[cnt]  <= sh_y0[cnt];
         act_y1[cnt]  <= sh_y1[cnt];
         if (cnt == '0) act_bg <= sh_bg;
      end
   end

   for (genvar i = 0; i < NUM_RECT; i++) begin : g_hit
      rect_hit #(.COORD_W(COORD_W)) u_hit (
         .en   (act_en[i]),
         .x0   (act_x0[i]),
         .x1   (act_x1[i]),
         .y0   (act_y0[i]),
         .y1   (act_y1[i]),
         .xpos (xpos),
         .ypos (ypos),
         .hit  (hit[i])
      );
   end

   // Walk from the top slot down so the lowest-index hit wins
   always_comb begin
      pix = act_bg;
      for (int i = NUM_RECT - 1; i >= 0; i--)
         if (hit[i]) pix = act_rgb[i];
      if (!valid) pix = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) {vga_r, vga_g, vga_b} <= 3'b000;
      else        {vga_r, vga_g, vga_b} <= pix;
   end
endmodule
